conv_accum_wb: RTL and testbench

Downstream stage of the convolution datapath's neuron/plane-ready counters. It consumes the per-cycle partial sums from the 4-lane MAC array and accumulates TAPS of them into one output neuron. It then adds the channel bias, rescales, applies optional ReLU, saturates, and emits one write (data + address) to the output feature-map buffer. It also tracks neurons per plane and flags plane completion and arithmetic saturation.

---
 rtl/conv_accum_wb_if.sv | 29 ++
 rtl/conv_accum_wb.sv | 134 +++++++++++++
 tb/tb_conv_accum_wb.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_accum_wb_if.sv
// Bundles the partial-sum input stream, the per-neuron control inputs,
// the output-buffer write port and the status flags of conv_accum_wb.
interface conv_accum_wb_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 16
);
    logic                     layer_start;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic signed [DATA_W-1:0] bias;
    logic                     relu_en;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  out_data;
    logic [15:0]              out_addr;
    logic                     plane_rdy;
    logic [7:0]               plane_idx;
    logic                     busy;
    logic                     sat_flag;

    modport master (
        output layer_start, in_valid, in_data, bias, relu_en,
        input  out_valid, out_data, out_addr, plane_rdy, plane_idx, busy, sat_flag
    );

    modport slave (
        input  layer_start, in_valid, in_data, bias, relu_en,
        output out_valid, out_data, out_addr, plane_rdy, plane_idx, busy, sat_flag
    );
endinterface

// File: rtl/conv_accum_wb.sv
// Accumulates TAPS partial sums per output neuron, adds the aligned bias,
// rescales, optionally applies ReLU, saturates and issues one write per
// neuron with a layer-global address and per-plane completion tracking.
module conv_accum_wb #(
    parameter int DATA_W     = 16,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 16,
    parameter int TAPS       = 25,
    parameter int PLANE_SIZE = 784,
    parameter int FRAC       = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    conv_accum_wb_if.slave bus
);
    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    localparam logic [7:0]              TAP_LAST = 8'(TAPS - 1);
    localparam logic [15:0]             NEU_LAST = 16'(PLANE_SIZE - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX  = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN  = ~OUT_MAX;

    state_t                  r_state, w_state_nxt;
    logic signed [ACC_W-1:0] r_acc, w_acc_nxt, w_acc_base;
    logic [7:0]              r_tap_cnt, w_tap_nxt, w_tap_base;
    logic [15:0]             r_neu_cnt, w_neu_base;
    logic [15:0]             r_addr;
    logic [7:0]              r_plane_idx;
    logic                    r_out_valid, r_plane_rdy, r_sat;
    logic signed [OUT_W-1:0] r_out_data;

    logic signed [ACC_W-1:0] w_data_ext, w_bias_sh, w_sum, w_shift, w_relu, w_clamped;
    logic                    w_last, w_clamp;

    // layer_start is folded in as "counters already zero", so a tap arriving
    // with it is handled by the same path as any ordinary tap 0.
    assign w_acc_base = bus.layer_start ? '0 : r_acc;
    assign w_tap_base = bus.layer_start ? '0 : r_tap_cnt;
    assign w_neu_base = bus.layer_start ? '0 : r_neu_cnt;
    assign w_last     = bus.in_valid && (w_tap_base == TAP_LAST);

    assign w_data_ext = {{(ACC_W-DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};
    assign w_bias_sh  = {{(ACC_W-DATA_W){bus.bias[DATA_W-1]}}, bus.bias} <<< FRAC;
    assign w_sum      = w_acc_base + w_data_ext + w_bias_sh;
    assign w_shift    = w_sum >>> FRAC;

    // Rescaled result: optional ReLU, then saturation to the output range.
    always_comb begin
        w_relu    = (bus.relu_en && (w_shift < 0)) ? '0 : w_shift;
        w_clamped = w_relu;
        w_clamp   = 1'b0;
        if (w_relu > OUT_MAX) begin
            w_clamped = OUT_MAX;
            w_clamp   = 1'b1;
        end else if (w_relu < OUT_MIN) begin
            w_clamped = OUT_MIN;
            w_clamp   = 1'b1;
        end
    end

    // Next state: count accepted taps, return to IDLE on the last one.
    always_comb begin
        w_state_nxt = bus.layer_start ? S_IDLE : r_state;
        w_acc_nxt   = w_acc_base;
        w_tap_nxt   = w_tap_base;
        if (bus.in_valid) begin
            if (w_last) begin
                w_state_nxt = S_IDLE;
                w_acc_nxt   = '0;
                w_tap_nxt   = '0;
            end else begin
                w_state_nxt = S_ACCUM;
                w_acc_nxt   = w_acc_base + w_data_ext;
                w_tap_nxt   = w_tap_base + 8'd1;
            end
        end
    end

    // Accumulator state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_tap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_tap_cnt <= w_tap_nxt;
        end
    end

    // Write strobe, result, plane completion and sticky saturation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_plane_rdy <= 1'b0;
            r_neu_cnt   <= '0;
            r_sat       <= 1'b0;
        end else begin
            r_out_valid <= w_last;
            r_plane_rdy <= w_last && (w_neu_base == NEU_LAST);
            r_sat       <= (r_sat && !bus.layer_start) || (w_last && w_clamp);
            r_neu_cnt   <= w_neu_base;
            if (w_last) begin
                r_out_data <= OUT_W'(w_clamped);
                r_neu_cnt  <= (w_neu_base == NEU_LAST) ? '0 : w_neu_base + 16'd1;
            end
        end
    end

    // Address and plane index advance on the edge after the strobe, so
    // they describe the write while it is being presented.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr      <= '0;
            r_plane_idx <= '0;
        end else if (bus.layer_start) begin
            r_addr      <= '0;
            r_plane_idx <= '0;
        end else begin
            if (r_out_valid) r_addr <= r_addr + 16'd1;
            if (r_plane_rdy) r_plane_idx <= r_plane_idx + 8'd1;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_addr  = r_addr;
    assign bus.plane_rdy = r_plane_rdy;
    assign bus.plane_idx = r_plane_idx;
    assign bus.busy      = (r_state == S_ACCUM);
    assign bus.sat_flag  = r_sat;
endmodule

// File: tb/tb_conv_accum_wb.sv
// Drives two differently configured conv_accum_wb instances with the same
// stimulus and compares every cycle against a neuron-level reference model.
module tb_conv_accum_wb;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    // Instance A: TAPS=3, PLANE_SIZE=2, FRAC=0. Instance B: TAPS=1, PLANE_SIZE=3, FRAC=8.
    int P_TAPS [2] = '{3, 1};
    int P_FRAC [2] = '{0, 8};
    int P_PS   [2] = '{2, 3};

    // Reference model state, per instance.
    int     m_taps   [2];
    longint m_sum    [2];
    int     m_writes [2];
    bit     m_sat    [2];
    bit     m_pend   [2];
    longint m_pdata  [2];

    conv_accum_wb_if #(.DATA_W(16), .OUT_W(16)) ifa ();
    conv_accum_wb_if #(.DATA_W(16), .OUT_W(16)) ifb ();

    conv_accum_wb #(.DATA_W(16), .ACC_W(32), .OUT_W(16), .TAPS(3), .PLANE_SIZE(2), .FRAC(0))
        u_a (.i_clk(clk), .i_rst_n(rst_n), .bus(ifa));
    conv_accum_wb #(.DATA_W(16), .ACC_W(32), .OUT_W(16), .TAPS(1), .PLANE_SIZE(3), .FRAC(8))
        u_b (.i_clk(clk), .i_rst_n(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_taps[k] = 0; m_sum[k] = 0; m_writes[k] = 0;
            m_sat[k] = 0; m_pend[k] = 0; m_pdata[k] = 0;
        end
    endtask

    // One neuron result from the arithmetic rules: wrap to 32 bits, floor
    // divide by 2^FRAC, ReLU, clamp to 16-bit signed.
    task automatic model_edge(input bit ls, input bit v, input int d, input int b, input bit relu);
        longint s, dv, q, md;
        int     s32;
        for (int k = 0; k < 2; k++) begin
            if (m_pend[k]) m_writes[k]++;
            m_pend[k] = 0;
            if (ls) begin
                m_taps[k] = 0; m_sum[k] = 0; m_writes[k] = 0; m_sat[k] = 0;
            end
            if (v) begin
                m_sum[k] += d;
                m_taps[k]++;
                if (m_taps[k] == P_TAPS[k]) begin
                    dv  = longint'(1) << P_FRAC[k];
                    s   = m_sum[k] + longint'(b) * dv;
                    s32 = int'(s);
                    md  = ((longint'(s32) % dv) + dv) % dv;
                    q   = (longint'(s32) - md) / dv;
                    if (relu && q < 0) q = 0;
                    if (q > 32767)  begin q = 32767;  m_sat[k] = 1; end
                    if (q < -32768) begin q = -32768; m_sat[k] = 1; end
                    m_pdata[k] = q;
                    m_pend[k]  = 1;
                    m_taps[k]  = 0;
                    m_sum[k]   = 0;
                end
            end
        end
    endtask

    task automatic check_dut(input int k, input logic vld, input logic signed [15:0] data,
                             input logic [15:0] addr, input logic rdy, input logic [7:0] pidx,
                             input logic busy, input logic sat);
        string p;
        p = (k == 0) ? "A" : "B";
        chk({p, "_valid"}, vld, m_pend[k]);
        chk({p, "_busy"}, busy, (m_taps[k] != 0));
        chk({p, "_sat"}, sat, m_sat[k]);
        chk({p, "_plane_idx"}, pidx, (m_writes[k] / P_PS[k]) % 256);
        chk({p, "_plane_rdy"}, rdy, m_pend[k] && (m_writes[k] % P_PS[k] == P_PS[k] - 1));
        if (m_pend[k]) begin
            chk({p, "_data"}, data, m_pdata[k]);
            chk({p, "_addr"}, addr, m_writes[k] % 65536);
        end
    endtask

    task automatic check_all();
        check_dut(0, ifa.out_valid, ifa.out_data, ifa.out_addr, ifa.plane_rdy, ifa.plane_idx, ifa.busy, ifa.sat_flag);
        check_dut(1, ifb.out_valid, ifb.out_data, ifb.out_addr, ifb.plane_rdy, ifb.plane_idx, ifb.busy, ifb.sat_flag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_A_out"}, {ifa.out_valid, ifa.out_data, ifa.out_addr, ifa.plane_rdy,
                              ifa.plane_idx, ifa.busy, ifa.sat_flag}, 0);
        chk({tag, "_B_out"}, {ifb.out_valid, ifb.out_data, ifb.out_addr, ifb.plane_rdy,
                              ifb.plane_idx, ifb.busy, ifb.sat_flag}, 0);
    endtask

    // Present one cycle of inputs, clock it, then compare just after the edge.
    task automatic step(input bit ls, input bit v, input int d, input int b, input bit relu);
        ifa.layer_start = ls; ifa.in_valid = v; ifa.in_data = 16'(d); ifa.bias = 16'(b); ifa.relu_en = relu;
        ifb.layer_start = ls; ifb.in_valid = v; ifb.in_data = 16'(d); ifb.bias = 16'(b); ifb.relu_en = relu;
        @(posedge clk);
        model_edge(ls, v, d, b, relu);
        #1;
        check_all();
    endtask

    // Reset pulse placed between clock edges.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int d, b;
        rst_n = 1'b0;
        ifa.layer_start = 0; ifa.in_valid = 0; ifa.in_data = '0; ifa.bias = '0; ifa.relu_en = 0;
        ifb.layer_start = 0; ifb.in_valid = 0; ifb.in_data = '0; ifb.bias = '0; ifb.relu_en = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Three taps plus bias 5 on A: 1+2+3+5 = 11 at address 0.
        step(0, 1, 1, 5, 0);
        chk("t1_busy1", ifa.busy, 1);
        step(0, 1, 2, 5, 0);
        chk("t1_busy2", ifa.busy, 1);
        step(0, 1, 3, 5, 0);
        chk("t1_valid", ifa.out_valid, 1);
        chk("t1_data", ifa.out_data, 11);
        chk("t1_addr", ifa.out_addr, 0);
        chk("t1_busy3", ifa.busy, 0);

        // Six unit taps: two writes of 3, plane completes on the second.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);
        chk("t2_data", ifa.out_data, 3);
        chk("t2_addr", ifa.out_addr, 1);
        chk("t2_rdy", ifa.plane_rdy, 1);
        chk("t2_pidx_during", ifa.plane_idx, 0);
        step(0, 0, 0, 0, 0);
        chk("t2_pidx_after", ifa.plane_idx, 1);

        // Saturation on B, then a ReLU-zeroed result leaves the flag set.
        step(1, 0, 0, 0, 0);
        step(0, 1, 32767, 32767, 0);
        chk("t3_sat_data", ifb.out_data, 32767);
        chk("t3_sat_flag", ifb.sat_flag, 1);
        step(0, 1, -512, 0, 1);
        chk("t3_relu_data", ifb.out_data, 0);
        chk("t3_sat_sticky", ifb.sat_flag, 1);

        // Gapped taps on A: 4+5+6 = 15.
        step(1, 0, 0, 0, 0);
        step(0, 1, 4, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 5, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 6, 0, 0);
        chk("t4_data", ifa.out_data, 15);

        // layer_start with tap 7 mid-neuron, then 1,1: 9 at address 0.
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(1, 1, 7, 0, 0);
        chk("t5_no_write", ifa.out_valid, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("t5_data", ifa.out_data, 9);
        chk("t5_addr", ifa.out_addr, 0);
        chk("t5_sat", ifa.sat_flag, 0);

        // Asynchronous reset while A is mid-neuron.
        step(0, 1, 3, 0, 0);
        async_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 2, 0, 0);
        chk("t6_addr", ifa.out_addr, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end else begin
                if ($urandom_range(0, 3) == 0) d = int'($urandom_range(0, 65535)) - 32768;
                else                           d = int'($urandom_range(0, 600)) - 300;
                if ($urandom_range(0, 3) == 0) b = int'($urandom_range(0, 65535)) - 32768;
                else                           b = int'($urandom_range(0, 60)) - 30;
                step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, d, b,
                     $urandom_range(0, 1) == 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
